// File: rtl/eda_neigh_stack_if.sv
// Push-side handshake between the window comparator and the neighbour stack.
// The comparator drives the mask and centre address; the stack answers with push_ready.
interface eda_neigh_stack_if #(
  parameter int WINDOW_WIDTH = 9,
  parameter int ADDR_WIDTH   = 6
);
  logic                    push_valid;
  logic                    push_ready;
  logic [WINDOW_WIDTH-2:0] push_positions;
  logic [ADDR_WIDTH-1:0]   center_addr;

  modport master (
    output push_valid,
    output push_positions,
    output center_addr,
    input  push_ready
  );

  modport slave (
    input  push_valid,
    input  push_positions,
    input  center_addr,
    output push_ready
  );
endinterface

// File: rtl/eda_neigh_stack.sv
// Serialises a 3x3 neighbour push mask into linear addresses, one per cycle,
// and holds them on a LIFO that the flood-fill controller pops.
`ifndef CFG_M
  `define CFG_M 8
`endif
`ifndef CFG_N
  `define CFG_N 8
`endif
`ifndef CFG_WINDOW_WIDTH
  `define CFG_WINDOW_WIDTH 9
`endif
`ifndef CFG_ADDR_WIDTH
  `define CFG_ADDR_WIDTH ($clog2(M * N))
`endif

module eda_neigh_stack #(
  parameter int M            = `CFG_M,
  parameter int N            = `CFG_N,
  parameter int WINDOW_WIDTH = `CFG_WINDOW_WIDTH,
  parameter int ADDR_WIDTH   = `CFG_ADDR_WIDTH,
  parameter int DEPTH        = 16,
  parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  eda_neigh_stack_if.slave      push_if,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] top_addr,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  busy,
  output logic                  overflow
);

  localparam int MASK_WIDTH = WINDOW_WIDTH - 1;
  localparam int IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PUSH = 1'b1;

  logic [0:0]            state;
  logic [MASK_WIDTH-1:0] mask_q;
  logic [MASK_WIDTH-1:0] mask_next;
  logic [ADDR_WIDTH-1:0] center_q;
  logic [CNT_WIDTH-1:0]  sp;
  logic [ADDR_WIDTH-1:0] stack_mem [DEPTH];

  logic [2:0]            sel;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] neigh_addr;
  logic                  wr_en;
  logic                  pop_en;
  logic                  at_full;
  logic                  store;
  logic [IDX_WIDTH-1:0]  top_idx;
  logic [IDX_WIDTH-1:0]  wr_idx;

  // Lowest set bit wins, so neighbours go out in ascending bit order.
  always_comb begin
    sel = '0;
    for (int k = MASK_WIDTH - 1; k >= 0; k--) begin
      if (mask_q[k]) sel = 3'(k);
    end
  end

  // Offsets wrap modulo 2^ADDR_WIDTH; upstream already masked out-of-image neighbours.
  always_comb begin
    offset = '0;
    case (sel)
      3'd0:    offset = ADDR_WIDTH'(-N - 1);
      3'd1:    offset = ADDR_WIDTH'(-N);
      3'd2:    offset = ADDR_WIDTH'(-N + 1);
      3'd3:    offset = ADDR_WIDTH'(-1);
      3'd4:    offset = ADDR_WIDTH'(1);
      3'd5:    offset = ADDR_WIDTH'(N - 1);
      3'd6:    offset = ADDR_WIDTH'(N);
      default: offset = ADDR_WIDTH'(N + 1);
    endcase
  end

  assign neigh_addr = center_q + offset;
  assign mask_next  = mask_q & (mask_q - MASK_WIDTH'(1));

  assign wr_en   = (state == PUSH);
  assign pop_en  = pop && (sp != '0);
  assign at_full = (sp == CNT_WIDTH'(DEPTH));
  // A simultaneous pop frees the top slot, so the write lands there even when full.
  assign store   = wr_en && (pop_en || !at_full);
  assign top_idx = IDX_WIDTH'(sp - CNT_WIDTH'(1));
  assign wr_idx  = pop_en ? top_idx : IDX_WIDTH'(sp);

  always_ff @(posedge clk) begin
    if (store && !clear) stack_mem[wr_idx] <= neigh_addr;
  end

  // Control path; clear outranks every other activity in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mask_q   <= '0;
      center_q <= '0;
      sp       <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      mask_q   <= '0;
      center_q <= '0;
      sp       <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (push_if.push_valid) begin
          mask_q   <= push_if.push_positions;
          center_q <= push_if.center_addr;
          if (push_if.push_positions != '0) state <= PUSH;
        end
      end else begin
        mask_q <= mask_next;
        if (mask_next == '0) state <= IDLE;
      end

      if (wr_en && !pop_en && !at_full) begin
        sp <= sp + CNT_WIDTH'(1);
      end else if (!wr_en && pop_en) begin
        sp <= sp - CNT_WIDTH'(1);
      end

      if (wr_en && !pop_en && at_full) overflow <= 1'b1;
    end
  end

  assign push_if.push_ready = (state == IDLE);
  assign busy     = (state == PUSH);
  assign count    = sp;
  assign empty    = (sp == '0);
  assign full     = at_full;
  assign top_addr = empty ? '0 : stack_mem[top_idx];

endmodule

// File: tb/tb_eda_neigh_stack.sv
// Directed bench for eda_neigh_stack with N=8, DEPTH=16 and hand-computed addresses.
module tb_eda_neigh_stack;

  localparam int AW = 6;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          pop;
  logic [AW-1:0] top_addr;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  int exp_ff [8] = '{18, 19, 20, 26, 28, 34, 35, 36};

  eda_neigh_stack_if #(.WINDOW_WIDTH(9), .ADDR_WIDTH(AW)) push_bus ();

  eda_neigh_stack #(
    .M(8), .N(8), .WINDOW_WIDTH(9), .ADDR_WIDTH(AW), .DEPTH(16), .CNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .push_if  (push_bus.slave),
    .pop      (pop),
    .top_addr (top_addr),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] mask, input logic [AW-1:0] center);
    push_bus.push_valid     = 1'b1;
    push_bus.push_positions = mask;
    push_bus.center_addr    = center;
    tick();
    push_bus.push_valid     = 1'b0;
    push_bus.push_positions = '0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (!push_bus.push_ready && n < 40) begin
      tick();
      n++;
    end
    ok = push_bus.push_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (push_bus.push_ready !== 1'b1 || empty !== 1'b1 || full !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags actual ready=%b empty=%b full=%b busy=%b expected 1 1 0 0",
               push_bus.push_ready, empty, full, busy);
    end
    checks++;
    if (count !== 5'd0 || top_addr !== 6'd0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values actual count=%0d top=%0d ovf=%b expected 0 0 0",
               count, top_addr, overflow);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_two_bits();
    send(8'b1000_0001, 6'd27);
    checks++;
    if (push_bus.push_ready !== 1'b0 || busy !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL t1_cycle1 actual ready=%b busy=%b count=%0d expected 0 1 0",
               push_bus.push_ready, busy, count);
    end
    tick();
    checks++;
    if (push_bus.push_ready !== 1'b0 || count !== 5'd1 || top_addr !== 6'd18) begin
      errors++;
      $display("[TB] FAIL t1_cycle2 actual ready=%b count=%0d top=%0d expected 0 1 18",
               push_bus.push_ready, count, top_addr);
    end
    tick();
    checks++;
    if (push_bus.push_ready !== 1'b1 || count !== 5'd2 || top_addr !== 6'd36) begin
      errors++;
      $display("[TB] FAIL t1_cycle3 actual ready=%b count=%0d top=%0d expected 1 2 36",
               push_bus.push_ready, count, top_addr);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if (top_addr !== 6'd18 || count !== 5'd1) begin
      errors++;
      $display("[TB] FAIL t1_pop1 actual top=%0d count=%0d expected 18 1", top_addr, count);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL t1_pop2 actual empty=%b count=%0d expected 1 0", empty, count);
    end
  endtask

  task automatic test_full_mask();
    send(8'hFF, 6'd27);
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (push_bus.push_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL t2_ready_c%0d actual=%b expected=0", i, push_bus.push_ready);
      end
      tick();
      checks++;
      if (top_addr !== AW'(exp_ff[i-1]) || count !== CW'(i)) begin
        errors++;
        $display("[TB] FAIL t2_write%0d actual top=%0d count=%0d expected %0d %0d",
                 i, top_addr, count, exp_ff[i-1], i);
      end
    end
    checks++;
    if (push_bus.push_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t2_ready_c9 actual ready=%b busy=%b expected 1 0",
               push_bus.push_ready, busy);
    end
    for (int i = 7; i >= 0; i--) begin
      checks++;
      if (top_addr !== AW'(exp_ff[i])) begin
        errors++;
        $display("[TB] FAIL t2_pop_top%0d actual=%0d expected=%0d", i, top_addr, exp_ff[i]);
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t2_empty actual=%b expected=1", empty);
    end
  endtask

  task automatic test_zero_mask();
    send(8'h00, 6'd27);
    checks++;
    if (push_bus.push_ready !== 1'b1 || busy !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL t3_zero actual ready=%b busy=%b count=%0d expected 1 0 0",
               push_bus.push_ready, busy, count);
    end
    tick();
    checks++;
    if (push_bus.push_ready !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL t3_zero_later actual ready=%b count=%0d expected 1 0",
               push_bus.push_ready, count);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    send(8'hFF, 6'd27);
    wait_idle(ok);
    send(8'h7F, 6'd27);
    wait_idle(ok);
    checks++;
    if (!ok || count !== 5'd15 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t4_preload actual idle=%b count=%0d ovf=%b expected 1 15 0",
               ok, count, overflow);
    end
    send(8'h03, 6'd27);
    wait_idle(ok);
    checks++;
    if (!ok || count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1 || top_addr !== 6'd18) begin
      errors++;
      $display("[TB] FAIL t4_overflow actual idle=%b count=%0d full=%b ovf=%b top=%0d expected 1 16 1 1 18",
               ok, count, full, overflow, top_addr);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (count !== 5'd0 || overflow !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t4_clear actual count=%0d ovf=%b empty=%b full=%b expected 0 0 1 0",
               count, overflow, empty, full);
    end
  endtask

  task automatic test_pop_write_full();
    bit ok;
    send(8'hFF, 6'd27);
    wait_idle(ok);
    send(8'hFF, 6'd27);
    wait_idle(ok);
    checks++;
    if (!ok || count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t5_fill actual idle=%b count=%0d full=%b ovf=%b expected 1 16 1 0",
               ok, count, full, overflow);
    end
    send(8'h10, 6'd40);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if (count !== 5'd16 || top_addr !== 6'd41 || overflow !== 1'b0 || push_bus.push_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t5_pop_write actual count=%0d top=%0d ovf=%b ready=%b expected 16 41 0 1",
               count, top_addr, overflow, push_bus.push_ready);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if (top_addr !== 6'd35 || count !== 5'd15) begin
      errors++;
      $display("[TB] FAIL t5_below actual top=%0d count=%0d expected 35 15", top_addr, count);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset_mid_push();
    send(8'h0F, 6'd27);
    tick();
    checks++;
    if (busy !== 1'b1 || count !== 5'd1 || top_addr !== 6'd18) begin
      errors++;
      $display("[TB] FAIL t6_before actual busy=%b count=%0d top=%0d expected 1 1 18",
               busy, count, top_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (push_bus.push_ready !== 1'b1 || busy !== 1'b0 || empty !== 1'b1 || count !== 5'd0 || top_addr !== 6'd0) begin
      errors++;
      $display("[TB] FAIL t6_async actual ready=%b busy=%b empty=%b count=%0d top=%0d expected 1 0 1 0 0",
               push_bus.push_ready, busy, empty, count, top_addr);
    end
    tick();
    reset = 1'b0;
    repeat (4) tick();
    checks++;
    if (count !== 5'd0 || busy !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t6_no_writes actual count=%0d busy=%b empty=%b expected 0 0 1",
               count, busy, empty);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || push_bus.push_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t6_pop_empty actual count=%0d empty=%b ovf=%b ready=%b expected 0 1 0 1",
               count, empty, overflow, push_bus.push_ready);
    end
  endtask

  initial begin
    clear                   = 1'b0;
    pop                     = 1'b0;
    push_bus.push_valid     = 1'b0;
    push_bus.push_positions = '0;
    push_bus.center_addr    = '0;
    test_reset();
    test_two_bits();
    test_full_mask();
    test_zero_mask();
    test_overflow();
    test_pop_write_full();
    test_reset_mid_push();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eda_neigh_stack.md
Name: eda_neigh_stack

Overview:
- Downstream stage of the window comparator in the regional-maxima flow.
- Consumes the 8-bit neighbour push mask and the centre pixel address.
- Serialises the masked neighbours into linear neighbour addresses, one per cycle.
- Keeps them on a LIFO stack that the flood-fill controller pops to schedule the next window fetch.

Parameters:
- M, `CFG_M: image rows.
- N, `CFG_N: image columns; the row stride for linear addressing.
- WINDOW_WIDTH, `CFG_WINDOW_WIDTH (9): pixels per 3x3 window; the mask is WINDOW_WIDTH-1 bits.
- ADDR_WIDTH, `CFG_ADDR_WIDTH: linear pixel address width (addr = row*N + col).
- DEPTH, 16: stack entries.
- CNT_WIDTH, $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- clear, input, 1: synchronous flush of stack, state and overflow flag.
- push_valid, input, 1: push_positions/center_addr are valid this cycle.
- push_ready, output, 1: block can accept a new mask.
- push_positions, input, WINDOW_WIDTH-1: neighbour mask from the comparator.
- center_addr, input, ADDR_WIDTH: linear address of the window centre.
- pop, input, 1: remove the top entry.
- top_addr, output, ADDR_WIDTH: current top of stack; valid when empty=0.
- empty, output, 1: stack holds no entries.
- full, output, 1: stack holds DEPTH entries.
- count, output, CNT_WIDTH: current occupancy.
- busy, output, 1: serialiser is in state PUSH.
- overflow, output, 1: sticky; a neighbour was dropped because the stack was full.

Behaviour:
- Reset (async, reset=1): state IDLE, stack pointer 0, latched mask 0, overflow 0.
  - Outputs: push_ready=1, empty=1, full=0, count=0, busy=0, top_addr=0.
- Mask bit k to window index: i=k for k<4, i=k+1 for k>=4. Window index 4 is the centre.
- Address offsets by bit 0..7: -N-1, -N, -N+1, -1, +1, N-1, N, N+1.
  - Arithmetic is modulo 2^ADDR_WIDTH, with no bounds check; the mask is already qualified by neigh_addr_valid upstream.
- FSM IDLE:
  - push_ready=1.
  - On push_valid=1: latch push_positions and center_addr.
  - Non-zero mask: go to PUSH next cycle.
  - Zero mask: stay IDLE, nothing is pushed.
- FSM PUSH:
  - push_ready=0 and busy=1.
  - Each cycle, select the lowest set bit of the latched mask, write center+offset to the stack, then clear that bit.
  - After the cycle that clears the last set bit, go to IDLE.
  - A k-bit mask accepted in cycle 0 writes in cycles 1..k; push_ready=1 again in cycle k+1.
- Push order: ascending bit index. After the whole mask is pushed, the highest-index neighbour is on top.
- Write visibility: an entry written in cycle t appears on top_addr and count in cycle t+1. top_addr is driven from the entry at pointer-1 (combinational read of the registered stack).
- Pop:
  - pop=1 with empty=0: pointer decrements and count drops by 1 next cycle.
  - pop on empty: ignored, no state change, no flag raised.
- Pop and write in the same cycle: the old top is removed and the new entry takes its slot. Count is unchanged and top_addr shows the new entry. This is allowed even when full=1; nothing is dropped.
- Write while full=1 without pop: the entry is dropped, overflow is set to 1, the mask bit is still cleared, and serialisation continues.
- overflow stays set until clear or reset.
- clear (sync) has priority over push, pop and FSM activity:
  - Returns to IDLE, pointer 0, mask 0, overflow 0.
  - A push_valid in the same cycle as clear is not accepted.
- Reset asserted mid-serialisation: all state is lost immediately; the remaining mask bits are discarded.
- full = (count==DEPTH); empty = (count==0).

Test Plan:
1. N=8, center_addr=27, mask 8'b1000_0001 -> writes 18 (cycle 1) then 36 (cycle 2); push_ready=0 in cycles 1-2 and 1 in cycle 3; count=2, top_addr=36; pop -> top_addr=18, count=1; pop -> empty=1.
2. N=8, center 27, mask 8'hFF -> 8 writes in order 18,19,20,26,28,34,35,36; push_ready=1 in cycle 9; 8 pops return 36,35,34,28,26,20,19,18.
3. Mask 0 with push_valid=1 -> state stays IDLE, push_ready stays 1, count unchanged.
4. DEPTH=16, preload 15 entries, push mask 8'h03 -> one entry stored, one dropped; count=16, full=1, overflow=1; clear -> count=0, overflow=0, empty=1.
5. Stack full, pop asserted in the same cycle as the serialiser writes 41 -> count stays 16, top_addr=41, overflow stays 0.
6. Assert reset mid-PUSH with 3 mask bits pending -> outputs return to reset values immediately; no writes occur after reset is released; pop on empty changes nothing.
